// File: rtl/drum_mac_accum_pkg.sv
// rtl/drum_mac_accum_pkg.sv - shared widths and FSM state type for the MAC accumulator
package drum_pkg;

  localparam int PRODUCT_W = 16;
  localparam int ACC_W     = 24;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } acc_state_t;

endpackage

// File: rtl/drum_mac_accum_if.sv
// rtl/drum_mac_accum_if.sv - product input and result output handshake bundle
interface drum_mac_accum_if #(
  parameter int PW = 16,
  parameter int AW = 24,
  parameter int CW = 8
) ();

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_product;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_overflow
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_overflow
  );

endinterface

// File: rtl/drum_mac_accum_sat_add.sv
// rtl/drum_mac_accum_sat_add.sv - signed adder with overflow flag; saturates when DRUM_ACC_SAT_EN is defined
module drum_sat_add #(
  parameter int AW = 24
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW-1:0] raw;

  // Overflow when both operands share a sign and the wrapped sum does not
  always_comb begin
    raw = a + b;
    ovf = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);
`ifdef DRUM_ACC_SAT_EN
    if (ovf) begin
      sum = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/drum_mac_accum.sv
// rtl/drum_mac_accum.sv - packet multiply-accumulate of signed products; optional saturation via DRUM_ACC_SAT_EN
module drum_mac_accum
  import drum_pkg::*;
#(
  parameter int PW = PRODUCT_W,
  parameter int AW = ACC_W,
  parameter int CW = CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  drum_mac_accum_if.slave    bus
);

  acc_state_t    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          in_ready;
  logic          accept;
  logic          pop;
  logic [AW-1:0] prod_ext;
  logic [AW-1:0] add_sum;
  logic          add_ovf;

  // A product arriving alongside clear is consumed by the handshake but dropped
  assign accept   = bus.in_valid & in_ready & ~clear;
  assign pop      = (state_q == ST_HOLD) & bus.out_ready;
  assign prod_ext = {{(AW-PW){bus.in_product[PW-1]}}, bus.in_product};

  drum_sat_add #(.AW(AW)) u_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: accumulate until in_last, then hold until the result is taken
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            state_d = bus.in_last ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: clear or a consumed result restart from zero
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear || pop) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      acc_d   = add_sum;
      count_d = (count_q == {CW{1'b1}}) ? count_q : count_q + 1'b1;
      ovf_d   = ovf_q | add_ovf;
    end
  end

  // Handshake outputs decoded from state; results come straight from registers
  always_comb begin
    in_ready         = (state_q != ST_HOLD);
    bus.in_ready     = in_ready;
    bus.out_valid    = (state_q == ST_HOLD);
    bus.out_acc      = acc_q;
    bus.out_count    = count_q;
    bus.out_overflow = ovf_q;
  end

endmodule

// File: tb/tb_drum_mac_accum.sv
// tb/tb_drum_mac_accum.sv - directed self-checking bench for drum_mac_accum
module tb_drum_mac_accum;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  int vectors = 0;
  int miscompares = 0;

  drum_mac_accum_if #(.PW(16), .AW(24), .CW(8)) bus ();

  drum_mac_accum #(.PW(16), .AW(24), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
  endtask

  // One product presented for exactly one clock edge
  task automatic send(input int prod, input logic last);
    bus.in_valid   = 1'b1;
    bus.in_product = 16'(prod);
    bus.in_last    = last;
    tick();
    idle_inputs();
  endtask

  task automatic send_repeat(input int prod, input int n);
    for (int i = 0; i < n; i++) begin
      send(prod, 1'b0);
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
    end
    vectors++;
    if (bus.out_acc !== 24'd0 || bus.out_count !== 8'd0 || bus.out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs: acc %0d cnt %0d ovf %0b want 0 0 0",
               bus.out_acc, bus.out_count, bus.out_overflow);
    end
  endtask

  task automatic test_basic();
    send(100, 1'b0);
    send(-30, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid: got %0b want 0", bus.out_valid);
    end
    send(7, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd77 || bus.out_count !== 8'd3 ||
        bus.out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: valid %0b acc %0d cnt %0d ovf %0b want 1 77 3 0",
               bus.out_valid, $signed(bus.out_acc), bus.out_count, bus.out_overflow);
    end
    pop();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_acc !== 24'd0) begin
      miscompares++;
      $display("FAIL basic_pop: valid %0b ready %0b acc %0d want 0 1 0",
               bus.out_valid, bus.in_ready, bus.out_acc);
    end
  endtask

  task automatic test_backpressure();
    send(5, 1'b0);
    send(5, 1'b1);
    // Keep offering a product to show it is refused while holding
    bus.in_valid   = 1'b1;
    bus.in_product = 16'd99;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd10 || bus.in_ready !== 1'b0 ||
          bus.out_count !== 8'd2) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid %0b acc %0d ready %0b cnt %0d want 1 10 0 2",
                 i, bus.out_valid, bus.out_acc, bus.in_ready, bus.out_count);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    idle_inputs();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_acc !== 24'd0 ||
        bus.out_count !== 8'd0) begin
      miscompares++;
      $display("FAIL bp_release: valid %0b ready %0b acc %0d cnt %0d want 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_acc, bus.out_count);
    end
  endtask

  task automatic test_overflow_pos();
    int exp_acc;
`ifdef DRUM_ACC_SAT_EN
    exp_acc = 8388607;
`else
    exp_acc = -6947116;
`endif
    send_repeat(32767, 300);
    send(0, 1'b1);
    vectors++;
    if (bus.out_acc !== 24'(exp_acc) || bus.out_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_pos: acc %0d ovf %0b want %0d 1",
               $signed(bus.out_acc), bus.out_overflow, exp_acc);
    end
    vectors++;
    if (bus.out_count !== 8'd255) begin
      miscompares++;
      $display("FAIL ovf_pos_count: got %0d want 255", bus.out_count);
    end
    pop();
    vectors++;
    if (bus.out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_sticky_cleared: got %0b want 0", bus.out_overflow);
    end
  endtask

  task automatic test_overflow_neg();
    int exp_acc;
`ifdef DRUM_ACC_SAT_EN
    exp_acc = -8388608;
`else
    exp_acc = 8355840;
`endif
    send_repeat(-32768, 257);
    send(0, 1'b1);
    vectors++;
    if (bus.out_acc !== 24'(exp_acc) || bus.out_overflow !== 1'b1 || bus.out_count !== 8'd255) begin
      miscompares++;
      $display("FAIL ovf_neg: acc %0d ovf %0b cnt %0d want %0d 1 255",
               $signed(bus.out_acc), bus.out_overflow, bus.out_count, exp_acc);
    end
    pop();
  endtask

  task automatic test_clear();
    send(1000, 1'b0);
    send(2000, 1'b0);
    clear          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_product = 16'd9;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_in_ready: got %0b want 1", bus.in_ready);
    end
    tick();
    clear = 1'b0;
    idle_inputs();
    vectors++;
    if (bus.out_acc !== 24'd0 || bus.out_count !== 8'd0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_regs: acc %0d cnt %0d valid %0b want 0 0 0",
               bus.out_acc, bus.out_count, bus.out_valid);
    end
    send(4, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd4 || bus.out_count !== 8'd1) begin
      miscompares++;
      $display("FAIL clear_next_pkt: valid %0b acc %0d cnt %0d want 1 4 1",
               bus.out_valid, bus.out_acc, bus.out_count);
    end
    pop();
  endtask

  task automatic test_reset_in_hold();
    send(11, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd11 || bus.out_count !== 8'd1) begin
      miscompares++;
      $display("FAIL rsthold_pre: valid %0b acc %0d cnt %0d want 1 11 1",
               bus.out_valid, bus.out_acc, bus.out_count);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rsthold_post: valid %0b ready %0b want 0 1", bus.out_valid, bus.in_ready);
    end
    send(3, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd3 || bus.out_count !== 8'd1) begin
      miscompares++;
      $display("FAIL rsthold_next_pkt: valid %0b acc %0d cnt %0d want 1 3 1",
               bus.out_valid, bus.out_acc, bus.out_count);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow_pos();
    test_overflow_neg();
    test_clear();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drum_mac_accum.md
Name: drum_mac_accum

Overview:
- Downstream consumer of the approximate signed multiplier; turns a stream of 16-bit signed products into a multiply-accumulate result.
- Accepts products over a valid/ready handshake and sums them into a wide signed accumulator.
- A packet is terminated by in_last. The final sum is presented on a valid/ready output port and held until it is taken.
- Sits between the multiplier output and the chip I/O byte-readout logic.

Parameters:
- PW, 16, product width in bits (signed two's complement; 2x multiplier operand width).
- AW, 24, accumulator width in bits (signed); must be >= PW+1.
- CW, 8, product-count width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous abort: drop the current packet and any held result
- in_valid  in  1  product valid
- in_ready  out  1  block can accept a product this cycle
- in_product  in  PW  signed product from the multiplier
- in_last  in  1  this product ends the packet
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- out_acc  out  AW  signed accumulated sum
- out_count  out  CW  number of products in the packet (saturating)
- out_overflow  out  1  sticky: signed overflow occurred in this packet

Behaviour:
- Reset is synchronous, active-low, on clk; clock is clk.
- Reset values: state=IDLE, acc=0, count=0, overflow=0, out_valid=0. in_ready=1 (driven combinationally from state).
- FSM states:
  - IDLE: nothing accumulated. in_ready=1.
  - ACCUM: at least one product accepted, no in_last yet. in_ready=1.
  - HOLD: result presented. in_ready=0, out_valid=1.
- Accept = in_valid & in_ready.
- On accept:
  - acc <= acc + sign_extend(in_product).
  - count <= count+1, saturating at 2^CW-1.
  - overflow <= overflow | signed_ovf.
- Transitions:
  - On accept with in_last=0: next state ACCUM.
  - On accept with in_last=1: next state HOLD.
- Latency: out_valid rises the cycle after the in_last product is accepted. out_acc includes that product.
- Single-product packet (in_last on the first accept from IDLE): HOLD next cycle, count=1.
- In HOLD:
  - out_acc, out_count and out_overflow are stable.
  - When out_valid & out_ready: acc=0, count=0, overflow=0, state IDLE next cycle. No new product is accepted in that same cycle; in_ready returns to 1 the following cycle.
- out_acc, out_count and out_overflow are registered and always reflect the internal registers. They are only meaningful while out_valid=1.
- signed_ovf: operands have the same sign and the AW-bit sum has a different sign.
- Default arithmetic wraps modulo 2^AW.
- Overflow is sticky until the packet is consumed or cleared.
- clear:
  - Priority: below rst_n, above all other inputs.
  - Effect: acc/count/overflow=0, state IDLE, out_valid=0 next cycle.
  - A product presented in the same cycle is not accepted; in_ready is still 1, so the upstream stage considers it consumed and dropped.
- Reset mid-packet: same effect as clear.
- in_product is taken verbatim as two's complement. No sign correction is applied to the multiplier's inverted-magnitude negative results.

Optional Feature:
- Macro: DRUM_ACC_SAT_EN.
- When defined: on signed_ovf, acc saturates to +(2^(AW-1)-1) for positive overflow or -(2^(AW-1)) for negative overflow. Later accepts continue from the saturated value. out_overflow is still set.
- When undefined: wrap-around modulo 2^AW. out_overflow is set identically.

Decomposition:
- Package drum_pkg holds:
  - Default width constants: PRODUCT_W=16, ACC_W=24, CNT_W=8.
  - FSM typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} acc_state_t.
- One sub-module, drum_sat_add (parameter AW): combinational signed adder.
  - Inputs: a[AW-1:0], b[AW-1:0].
  - Outputs: sum[AW-1:0] and ovf.
  - Saturation logic is conditional on DRUM_ACC_SAT_EN.
- drum_mac_accum holds the FSM, the registers and the handshake.

Test Plan:
- Basic packet: products 100, -30, 7 (last), out_ready=1 -> out_valid the cycle after the last accept; out_acc=77, out_count=3, out_overflow=0.
- Backpressure: packet 5, 5 (last) with out_ready held 0 for 4 cycles -> out_valid and out_acc=10 stable, in_ready=0 throughout. Raise out_ready -> IDLE next cycle, in_ready=1 the cycle after.
- Overflow: 300 accepts of 32767, then a last of 0 (AW=24, product sum 9830100 > 8388607).
  - Without macro: out_acc=9830100-16777216=-6947116, out_overflow=1.
  - With DRUM_ACC_SAT_EN: out_acc=8388607, out_overflow=1.
  - Both: out_count=255 (saturated).
- Negative saturation (macro on): 257 accepts of -32768, then last 0 -> out_acc=-8388608, out_overflow=1. Without macro: out_acc=-8421376+16777216=8355840, out_overflow=1.
- clear mid-packet: accept 1000, 2000, then clear together with in_valid=1, product 9 -> product 9 ignored. New packet 4 (last) -> out_acc=4, out_count=1.
- Reset in HOLD: rst_n=0 for one cycle while out_valid=1 -> out_valid=0, in_ready=1, and the next packet starts from acc=0.
